// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit: IF/ID/EX/MEM/WB sequencing with memory handshakes,
// wait timeout trap and optional performance counters (define MCTRL_PERF_EN).
//
// state | meaning
// RST   | post-reset idle, all outputs low
// IF    | instruction fetch, waits on imem_rdy
// ID    | decode / address generation, jumps resolve here
// EX    | operand latch, branches resolve here
// MEM   | data memory access, waits on dmem_rdy
// WB    | register write-back
// FAULT | sticky trap, left only by reset
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             imem_rdy,
  input  logic             dmem_rdy,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             ir_we,
  output logic             addr_gen,
  output logic             rs_we,
  output logic             rt_we,
  output logic [1:0]       reg_dst,
  output logic             alu_src,
  output logic [2:0]       alu_ctrl,
  output logic [1:0]       mem_to_reg,
  output logic             reg_wr,
  output logic             mem_wr,
  output logic             jump,
  output logic             beq,
  output logic             bne,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EX    = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_RST   = 3'd5,
    S_FAULT = 3'd7
  } state_t;

  localparam int WAIT_W = $clog2(TIMEOUT + 2);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  state_t state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic waiting, wait_expired;

  logic is_r, is_add, is_sub, is_slt, is_jr, is_j, is_jal;
  logic is_addi, is_xori, is_lw, is_sw, is_beq, is_bne, is_alu;
  logic [1:0] dec_reg_dst, dec_mem_to_reg;
  logic       dec_alu_src;
  logic [2:0] dec_alu_ctrl;

  assign is_r    = (opcode == 6'h00);
  assign is_add  = is_r && (funct == 6'h20);
  assign is_sub  = is_r && (funct == 6'h22);
  assign is_slt  = is_r && (funct == 6'h2a);
  assign is_jr   = is_r && (funct == 6'h08);
  assign is_j    = (opcode == 6'h02);
  assign is_jal  = (opcode == 6'h03);
  assign is_addi = (opcode == 6'h08);
  assign is_xori = (opcode == 6'h0e);
  assign is_lw   = (opcode == 6'h23);
  assign is_sw   = (opcode == 6'h2b);
  assign is_beq  = (opcode == 6'h04);
  assign is_bne  = (opcode == 6'h05);
  assign is_alu  = is_add | is_sub | is_slt | is_addi | is_xori;

  always_comb begin
    dec_reg_dst    = 2'd0;
    dec_alu_src    = 1'b0;
    dec_alu_ctrl   = 3'd0;
    dec_mem_to_reg = 2'd0;
    if (is_sub | is_beq | is_bne) dec_alu_ctrl = 3'd1;
    if (is_xori)                  dec_alu_ctrl = 3'd2;
    if (is_slt)                   dec_alu_ctrl = 3'd3;
    if (is_addi | is_xori | is_lw) dec_reg_dst = 2'd2;
    if (is_addi | is_xori | is_lw | is_sw) dec_alu_src = 1'b1;
    if (is_lw) dec_mem_to_reg = 2'd1;
    if (is_jal) begin
      dec_reg_dst    = 2'd1;
      dec_mem_to_reg = 2'd2;
    end
  end

  // Wait cycles are counted only while the active handshake is low; rdy in the last allowed cycle wins.
  assign waiting      = ((state_q == S_IF) && !imem_rdy) || ((state_q == S_MEM) && !dmem_rdy);
  assign wait_expired = (TIMEOUT != 0) && waiting && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RST;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      if ((TIMEOUT != 0) && waiting && !wait_expired) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                                           wait_cnt <= '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    ir_we      = 1'b0;
    addr_gen   = 1'b0;
    rs_we      = 1'b0;
    rt_we      = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    jump       = 1'b0;
    beq        = 1'b0;
    bne        = 1'b0;
    fault      = 1'b0;
    reg_dst    = 2'd0;
    alu_src    = 1'b0;
    alu_ctrl   = 3'd0;
    mem_to_reg = 2'd0;
    unique case (state_q)
      S_RST: state_d = S_IF;
      S_IF: begin
        imem_req = 1'b1;
        ir_we    = imem_rdy;
        if (imem_rdy)          state_d = S_ID;
        else if (wait_expired) state_d = S_FAULT;
      end
      S_ID: begin
        addr_gen = 1'b1;
        jump     = is_j | is_jr | is_jal;
        if (is_j | is_jr)                                  state_d = S_IF;
        else if (is_jal)                                   state_d = S_WB;
        else if (is_alu | is_lw | is_sw | is_beq | is_bne) state_d = S_EX;
        else                                               state_d = S_FAULT;
      end
      S_EX: begin
        rs_we = 1'b1;
        rt_we = 1'b1;
        beq   = is_beq;
        bne   = is_bne;
        if (is_lw | is_sw)        state_d = S_MEM;
        else if (is_beq | is_bne) state_d = S_IF;
        else                      state_d = S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        mem_wr   = is_sw;
        if (dmem_rdy)          state_d = is_lw ? S_WB : S_IF;
        else if (wait_expired) state_d = S_FAULT;
      end
      S_WB: begin
        reg_wr  = is_alu | is_lw | is_jal;
        state_d = S_IF;
      end
      S_FAULT: fault = 1'b1;
      default: state_d = S_FAULT;
    endcase
    if (state_q inside {S_ID, S_EX, S_MEM, S_WB}) begin
      reg_dst    = dec_reg_dst;
      alu_src    = dec_alu_src;
      alu_ctrl   = dec_alu_ctrl;
      mem_to_reg = dec_mem_to_reg;
    end
  end

  assign state = state_q;

`ifdef MCTRL_PERF_EN
  logic [CNT_W-1:0] cycle_q, instret_q;
  logic retire;

  assign retire = (state_q inside {S_ID, S_EX, S_MEM, S_WB}) && (state_d == S_IF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if ((state_q != S_RST) && (state_q != S_FAULT)) cycle_q <= cycle_q + CNT_W'(1);
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus random instruction mix, checked
// against a per-instruction state-path model derived from the instruction class.
module tb_multicycle_ctrl;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 8;

  localparam int S_IF = 0, S_ID = 1, S_EX = 2, S_MEM = 3, S_WB = 4, S_RST = 5, S_FAULT = 7;
  localparam int C_ALU = 0, C_J = 1, C_JAL = 2, C_LW = 3, C_SW = 4, C_BR = 5, C_ILL = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic imem_rdy = 1'b0, dmem_rdy = 1'b0;
  logic imem_req, dmem_req, ir_we, addr_gen, rs_we, rt_we, alu_src;
  logic reg_wr, mem_wr, jump, beq, bne, fault;
  logic [1:0] reg_dst, mem_to_reg;
  logic [2:0] alu_ctrl, state;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  int n_pass = 0;
  int n_total = 0;
  logic [CNT_W-1:0] m_cyc = '0, m_ret = '0;
  int path[$];

  logic [5:0] op_tab [14] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h08,
                              6'h0e, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h3f, 6'h00};
  logic [5:0] fn_tab [14] = '{6'h20, 6'h22, 6'h2a, 6'h08, 6'h00, 6'h00, 6'h00,
                              6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h21};

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_we(ir_we),
    .addr_gen(addr_gen), .rs_we(rs_we), .rt_we(rt_we),
    .reg_dst(reg_dst), .alu_src(alu_src), .alu_ctrl(alu_ctrl), .mem_to_reg(mem_to_reg),
    .reg_wr(reg_wr), .mem_wr(mem_wr), .jump(jump), .beq(beq), .bne(bne),
    .fault(fault), .state(state), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int cls(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        if (fn == 6'h20 || fn == 6'h22 || fn == 6'h2a) return C_ALU;
        if (fn == 6'h08) return C_J;
        return C_ILL;
      end
      6'h02:        return C_J;
      6'h03:        return C_JAL;
      6'h08, 6'h0e: return C_ALU;
      6'h23:        return C_LW;
      6'h2b:        return C_SW;
      6'h04, 6'h05: return C_BR;
      default:      return C_ILL;
    endcase
  endfunction

  // {reg_dst, alu_src, alu_ctrl, mem_to_reg}
  function automatic logic [7:0] sdec(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        if (fn == 6'h22) return 8'b00_0_001_00;
        if (fn == 6'h2a) return 8'b00_0_011_00;
        return 8'h00;
      end
      6'h08:        return 8'b10_1_000_00;
      6'h0e:        return 8'b10_1_010_00;
      6'h23:        return 8'b10_1_000_01;
      6'h2b:        return 8'b00_1_000_00;
      6'h04, 6'h05: return 8'b00_0_001_00;
      6'h03:        return 8'b01_0_000_10;
      default:      return 8'h00;
    endcase
  endfunction

  function automatic logic [22:0] exp_out(input int st, input logic [5:0] op,
                                          input logic [5:0] fn, input logic ir);
    logic [7:0] sc;
    logic [5:0] hs, ls;
    int c;
    c  = cls(op, fn);
    sc = (st >= S_ID && st <= S_WB) ? sdec(op, fn) : 8'h00;
    hs = '0;
    ls = '0;
    case (st)
      S_IF:    hs = {1'b1, 1'b0, ir, 3'b000};
      S_ID:    begin hs = 6'b000100; ls[3] = (c == C_J || c == C_JAL); end
      S_EX:    begin hs = 6'b000011; ls[2] = (op == 6'h04); ls[1] = (op == 6'h05); end
      S_MEM:   begin hs = 6'b010000; ls[4] = (op == 6'h2b); end
      S_WB:    ls[5] = (c == C_ALU || c == C_LW || c == C_JAL);
      S_FAULT: ls[0] = 1'b1;
      default: ;
    endcase
    return {hs, sc, ls, 3'(st)};
  endfunction

  function automatic logic [22:0] obs_out();
    return {imem_req, dmem_req, ir_we, addr_gen, rs_we, rt_we, reg_dst, alu_src, alu_ctrl,
            mem_to_reg, reg_wr, mem_wr, jump, beq, bne, fault, state};
  endfunction

  function automatic logic [31:0] exp_cnt();
`ifdef MCTRL_PERF_EN
    return 32'({m_cyc, m_ret});
`else
    return 32'h0;
`endif
  endfunction

  // One clock in state st whose successor is nxt; called right after a falling edge.
  task automatic cycle(input int st, input int nxt, input string tag);
    imem_rdy = (st == S_IF)  ? (nxt == S_ID) : 1'($urandom);
    dmem_rdy = (st == S_MEM) ? (nxt == S_WB || nxt == S_IF) : 1'($urandom);
    #1;
    check({tag, " outs"}, 32'(obs_out()), 32'(exp_out(st, opcode, funct, imem_rdy)));
    check({tag, " cnts"}, 32'({cycle_cnt, instret_cnt}), exp_cnt());
    @(posedge clk);
    if (st != S_RST && st != S_FAULT) m_cyc++;
    if (st >= S_ID && st <= S_WB && nxt == S_IF) m_ret++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_cyc = '0;
    m_ret = '0;
    @(negedge clk);
    #1;
    check("reset outs", 32'(obs_out()), 32'(exp_out(S_RST, opcode, funct, 1'b0)));
    check("reset cnts", 32'({cycle_cnt, instret_cnt}), 32'h0);
    #1 rst_n = 1'b1;
    cycle(S_RST, S_IF, "rst_exit");
  endtask

  task automatic build_path(input int c, input int iw, input int dw);
    path.delete();
    if (iw >= TIMEOUT) begin
      repeat (TIMEOUT) path.push_back(S_IF);
      path.push_back(S_FAULT);
      return;
    end
    repeat (iw + 1) path.push_back(S_IF);
    path.push_back(S_ID);
    case (c)
      C_ILL: path.push_back(S_FAULT);
      C_JAL: path.push_back(S_WB);
      C_ALU: begin path.push_back(S_EX); path.push_back(S_WB); end
      C_BR:  path.push_back(S_EX);
      C_LW, C_SW: begin
        path.push_back(S_EX);
        if (dw >= TIMEOUT) begin
          repeat (TIMEOUT) path.push_back(S_MEM);
          path.push_back(S_FAULT);
          return;
        end
        repeat (dw + 1) path.push_back(S_MEM);
        if (c == C_LW) path.push_back(S_WB);
      end
      default: ;
    endcase
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int iw, input int dw, input string tag);
    opcode = op;
    funct  = fn;
    build_path(cls(op, fn), iw, dw);
    for (int i = 0; i < path.size(); i++) begin
      int nxt;
      if (path[i] == S_FAULT)    nxt = S_FAULT;
      else if (i + 1 < path.size()) nxt = path[i + 1];
      else                       nxt = S_IF;
      cycle(path[i], nxt, tag);
    end
    if (path[path.size() - 1] == S_FAULT) begin
      repeat (3) begin
        opcode = 6'($urandom);
        funct  = 6'($urandom);
        cycle(S_FAULT, S_FAULT, {tag, " hold"});
      end
      do_reset();
    end
  endtask

  initial begin
    do_reset();
    run_instr(6'h00, 6'h20, 0, 0, "add");
    run_instr(6'h23, 6'($urandom), 0, 3, "lw_wait3");
    run_instr(6'h2b, 6'($urandom), 0, 0, "sw");
    run_instr(6'h04, 6'($urandom), 0, 0, "beq");
    run_instr(6'h05, 6'($urandom), 1, 0, "bne");
    run_instr(6'h03, 6'($urandom), 0, 0, "jal");
    run_instr(6'h00, 6'h08, 0, 0, "jr");
    run_instr(6'h00, 6'h2a, 3, 0, "slt_last_wait");
    run_instr(6'h23, 6'($urandom), 0, 3, "lw_last_wait");
    run_instr(6'h00, 6'h20, 20, 0, "if_timeout");
    run_instr(6'h08, 6'($urandom), 0, 0, "addi");
    run_instr(6'h3f, 6'($urandom), 0, 0, "illegal");
    run_instr(6'h2b, 6'($urandom), 0, 4, "mem_timeout");

    // Asynchronous reset while SW sits in MEM with dmem_rdy high.
    opcode = 6'h2b;
    funct  = 6'($urandom);
    cycle(S_IF, S_ID, "midrst");
    cycle(S_ID, S_EX, "midrst");
    cycle(S_EX, S_MEM, "midrst");
    dmem_rdy = 1'b1;
    imem_rdy = 1'b0;
    #1;
    check("midrst mem_wr before", 32'(mem_wr), 32'h1);
    rst_n = 1'b0;
    #1;
    check("midrst mem_wr after", 32'(mem_wr), 32'h0);
    check("midrst state", 32'(state), 32'h5);
    check("midrst cnts", 32'({cycle_cnt, instret_cnt}), 32'h0);
    @(negedge clk);
    do_reset();

    for (int k = 0; k < 200; k++) begin
      int idx, iw, dw;
      logic [5:0] fn;
      idx = $urandom_range(0, 13);
      iw  = ($urandom_range(0, 14) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3);
      dw  = ($urandom_range(0, 14) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3);
      fn  = (op_tab[idx] == 6'h00) ? fn_tab[idx] : 6'($urandom);
      run_instr(op_tab[idx], fn, iw, dw, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multicycle CPU control unit. It sequences each instruction through IF/ID/EX/MEM/WB and asserts datapath strobes only in the states where they apply. Unlike a fixed-latency controller, it handshakes with variable-latency instruction and data memories and traps to a sticky fault state on illegal opcodes or memory timeouts. It can also compile in performance counters. It sits between the instruction register and the datapath/register-file/memory ports of the multicycle CPU.

## Interface
- TIMEOUT, 16: maximum consecutive wait cycles on a memory handshake before faulting; 0 disables timeout.
- CNT_W, 32: width of performance counters.
- clk in 1: system clock, all state on rising edge.
- rst_n in 1: asynchronous, active-low reset.
- opcode in 6, funct in 6: fields from the instruction register; stable from ID until next IF completes.
- imem_rdy in 1, dmem_rdy in 1: memory completion handshakes.
- imem_req out 1, dmem_req out 1: memory requests.
- ir_we out 1: instruction register write enable.
- addr_gen out 1, rs_we out 1, rt_we out 1: address-generation strobe, operand register enables.
- reg_dst out 2 (0 rd, 1 r31, 2 rt), alu_src out 1, alu_ctrl out 3 (0 add, 1 sub, 2 xor, 3 slt), mem_to_reg out 2 (0 ALU, 1 mem, 2 PC+4): static controls.
- reg_wr out 1, mem_wr out 1, jump out 1, beq out 1, bne out 1: strobes.
- fault out 1: sticky trap indicator.
- state out 3: current state, for debug.
- cycle_cnt out CNT_W, instret_cnt out CNT_W: performance counters.

## Operation
- States: RST=5, IF=0, ID=1, EX=2, MEM=3, WB=4, FAULT=7.
- Reset enters RST, with all outputs 0. RST goes to IF unconditionally.
- IF:
  - imem_req=1.
  - ir_we = imem_rdy (combinational).
  - On imem_rdy, go to ID; otherwise stay.
- ID:
  - addr_gen=1; decode opcode/funct.
  - jump=1 for J, JR (opcode 0, funct 0x08), and JAL.
  - Next state: J/JR→IF; JAL→WB; ADD/SUB/SLT/ADDI/XORI/LW/SW/BEQ/BNE→EX; anything else→FAULT.
- EX:
  - rs_we=rt_we=1.
  - beq=1 for BEQ; bne=1 for BNE.
  - Next state: LW/SW→MEM; BEQ/BNE→IF; others→WB.
- MEM:
  - dmem_req=1; mem_wr=1 for SW.
  - On dmem_rdy, LW→WB and SW→IF; otherwise stay.
- WB: reg_wr=1 for ADD, SUB, SLT, ADDI, XORI, LW, JAL; then go to IF.
- FAULT: fault=1 and every other strobe is 0. FAULT is left only by reset.
- Static controls are a combinational decode of opcode/funct in ID/EX/MEM/WB and are forced to 0 in RST/IF/FAULT:
  - ADD (0x20): alu_ctrl 0.
  - SUB (0x22): alu_ctrl 1.
  - SLT (0x2a): alu_ctrl 3.
  - ADDI (0x08): reg_dst 2, alu_src 1, alu_ctrl 0.
  - XORI (0x0e): reg_dst 2, alu_src 1, alu_ctrl 2.
  - LW (0x23): reg_dst 2, alu_src 1, mem_to_reg 1.
  - SW (0x2b): alu_src 1.
  - BEQ (0x04), BNE (0x05): alu_ctrl 1.
  - JAL (0x03): reg_dst 1, mem_to_reg 2.
  - All other fields are 0.
- Wait counter:
  - Counts consecutive cycles in IF or MEM with rdy low.
  - Clears on rdy or on state change.
  - When the count reaches TIMEOUT with rdy still low, the next state is FAULT.
  - rdy arriving in the final allowed cycle wins.
- imem_rdy and dmem_rdy are ignored outside IF and MEM respectively.

## Timing
- Zero-wait latencies (cycles):
  - J/JR: 2.
  - BEQ/BNE: 3.
  - JAL: 3.
  - R-type/ADDI/XORI: 4.
  - SW: 4.
  - LW: 5.
- Each memory wait cycle adds 1.
- All strobes are single-state: each is high for exactly the cycles spent in its state.
- ir_we is the only input-to-output combinational path besides the static decode.
- First IF occurs the 2nd rising edge after rst_n deasserts.
- rst_n asserted mid-instruction immediately forces RST, all outputs 0, counters 0, wait counter 0. No partial mem_wr or reg_wr may follow.

## Configuration
- MCTRL_PERF_EN defined:
  - cycle_cnt increments every cycle outside RST.
  - instret_cnt increments on each transition into IF from ID, EX, MEM, or WB.
  - Both wrap at 2^CNT_W and freeze in FAULT.
- MCTRL_PERF_EN undefined: both ports are tied to 0 and no counter flops are inferred.

## Test plan
- Reset, then ADD (opcode 0, funct 0x20) with imem_rdy=1: states RST,IF,ID,EX,WB,IF. reg_wr=1 only in WB. alu_ctrl=0 and reg_dst=0 during ID–WB.
- LW with dmem_rdy low for 3 cycles: MEM held 3 extra cycles with dmem_req=1. reg_wr=1, mem_to_reg=1, reg_dst=2 in WB. Total latency 8.
- SW followed by BEQ: mem_wr=1 only during MEM. beq=1 exactly one cycle in EX. Next IF directly after EX.
- TIMEOUT=4, imem_rdy stuck low: FAULT after 4 wait cycles, fault=1 held, all strobes 0. rst_n pulse returns to RST.
- Opcode 0x3f in ID: next state FAULT. With MCTRL_PERF_EN, instret_cnt is unchanged and cycle_cnt freezes.
- rst_n asserted during MEM of SW with dmem_rdy=1: mem_wr drops to 0 asynchronously and state=5.
